// File: rtl/loa_share_pkg.sv
// Shared constants and round-robin helper for the LOA sharing arbiter family.
package loa_share_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned LOA_M   = 16;
  localparam int unsigned MAX_REQ = 8;
  localparam int unsigned PTR_W   = 3;

  // First valid index after ptr (wrapping modulo nreq); returns ptr when nothing is valid.
  function automatic logic [PTR_W-1:0] rr_next(input logic [PTR_W-1:0]   ptr,
                                               input logic [MAX_REQ-1:0] valid,
                                               input int unsigned        nreq);
    logic [PTR_W-1:0] sel;
    logic             found;
    int unsigned      idx;
    sel   = ptr;
    found = 1'b0;
    for (int unsigned k = 1; k <= MAX_REQ; k++) begin
      idx = (32'(ptr) + k) % nreq;
      if (!found && (k <= nreq) && valid[PTR_W'(idx)]) begin
        sel   = PTR_W'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/loa_16.sv
// Lower-part-OR approximate adder: OR in the low 16 bits, exact add above with one carry hint.
module loa_16
  import loa_share_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] s
);

  localparam int unsigned HI_W = DATA_W - LOA_M;

  logic c_m;

  assign c_m               = a[LOA_M-1] & b[LOA_M-1];
  assign s[LOA_M-1:0]      = a[LOA_M-1:0] | b[LOA_M-1:0];
  assign s[DATA_W-1:LOA_M] = a[DATA_W-1:LOA_M] + b[DATA_W-1:LOA_M] + HI_W'(c_m);

endmodule

// File: rtl/loa_share_arb_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant plus encoded index.
module rr_arbiter
  import loa_share_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IDW-1:0]  ptr,
  input  logic            enable,
  output logic [NREQ-1:0] grant_c,
  output logic [IDW-1:0]  grant_idx_c
);

  logic [MAX_REQ-1:0] valid_ext;
  logic [PTR_W-1:0]   sel;

  always_comb begin
    valid_ext = '0;
    for (int unsigned i = 0; i < NREQ; i++) valid_ext[i] = valid[i];
    sel         = rr_next(PTR_W'(ptr), valid_ext, NREQ);
    grant_idx_c = IDW'(sel);
    grant_c     = '0;
    if (enable && (|valid)) grant_c[grant_idx_c] = 1'b1;
  end

endmodule

// File: rtl/loa_share_arb.sv
// Time-shares one LOA_16 adder among NREQ requesters with round-robin grant
// and a single backpressured result register.
module loa_share_arb
  import loa_share_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*DATA_W-1:0] req_a,
  input  logic [NREQ*DATA_W-1:0] req_b,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [DATA_W-1:0]      resp_sum,
  output logic [IDW-1:0]         resp_id,
  output logic [31:0]            op_count
);

  logic [IDW-1:0]    rr_q, rr_d;
  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_sum_q, resp_sum_d;
  logic [IDW-1:0]    resp_id_q, resp_id_d;
  logic [31:0]       op_count_q, op_count_d;

  logic              accept_c;
  logic              handshake_c;
  logic [NREQ-1:0]   grant_c;
  logic [IDW-1:0]    grant_idx_c;
  logic [DATA_W-1:0] op_a_c, op_b_c, loa_sum_c;

  // A draining stage accepts in the same cycle, so back-to-back results need no bubble.
  assign accept_c    = !resp_valid_q || resp_ready;
  assign req_ready   = grant_c;
  assign handshake_c = |grant_c;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .valid       (req_valid),
    .ptr         (rr_q),
    .enable      (accept_c && !rst),
    .grant_c     (grant_c),
    .grant_idx_c (grant_idx_c)
  );

  always_comb begin
    op_a_c = '0;
    op_b_c = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_idx_c == IDW'(i)) begin
        op_a_c = req_a[i*DATA_W +: DATA_W];
        op_b_c = req_b[i*DATA_W +: DATA_W];
      end
    end
  end

  loa_16 u_loa (
    .a (op_a_c),
    .b (op_b_c),
    .s (loa_sum_c)
  );

  always_comb begin
    rr_d         = rr_q;
    resp_valid_d = resp_valid_q;
    resp_sum_d   = resp_sum_q;
    resp_id_d    = resp_id_q;
    op_count_d   = op_count_q;
    if (resp_valid_q && resp_ready) op_count_d = op_count_q + 32'd1;
    if (accept_c) begin
      resp_valid_d = handshake_c;
      if (handshake_c) begin
        resp_sum_d = loa_sum_c;
        resp_id_d  = grant_idx_c;
        rr_d       = grant_idx_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q         <= IDW'(NREQ - 1);
      resp_valid_q <= 1'b0;
      resp_sum_q   <= '0;
      resp_id_q    <= '0;
      op_count_q   <= '0;
    end else begin
      rr_q         <= rr_d;
      resp_valid_q <= resp_valid_d;
      resp_sum_q   <= resp_sum_d;
      resp_id_q    <= resp_id_d;
      op_count_q   <= op_count_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_sum   = resp_sum_q;
  assign resp_id    = resp_id_q;
  assign op_count   = op_count_q;

endmodule

// File: doc/loa_share_arb.md
Name: loa_share_arb

Overview:
- Time-shares one 32-bit lower-part-OR approximate adder (LOA_16, M=16) among NREQ independent requesters.
- Round-robin arbitration; valid/ready handshake per requester; one registered result stage with backpressure.
- Tags each result with the requester id and counts completed operations.
- Sits between the approximate-arithmetic clients and the single shared LOA datapath, so the adder is not replicated per client.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, id width; must equal clog2(NREQ).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  requester i presents an operand pair.
- req_ready  output  NREQ  requester i's pair is consumed this cycle.
- req_a  input  NREQ*32  packed operand A; requester i uses bits [32i+31:32i].
- req_b  input  NREQ*32  packed operand B; same packing as req_a.
- resp_valid  output  1  result register holds a result.
- resp_ready  input  1  consumer accepts the result this cycle.
- resp_sum  output  32  approximate sum.
- resp_id  output  IDW  index of the requester that produced resp_sum.
- op_count  output  32  number of completed response handshakes.

Behaviour:
- Reset (rst=1 at a clock edge) forces: resp_valid=0, resp_sum=0, resp_id=0, op_count=0, rr pointer=NREQ-1.
  - With rr pointer=NREQ-1, requester 0 has highest priority after reset.
  - Reset mid-operation discards any held result; nothing is replayed.
  - req_ready is forced to 0 while rst=1.
- Accept condition: accept = !resp_valid || resp_ready.
  - An empty stage accepts.
  - A full stage draining in the same cycle also accepts, giving full throughput with no bubble.
- Grant selection:
  - Scan indices ptr+1, ptr+2, … modulo NREQ; pick the first with req_valid=1.
  - req_ready[i] = accept && grant[i]; grant is one-hot or all zero.
  - req_ready depends combinationally on req_valid and resp_ready; no other combinational path to outputs.
- On a handshake (req_valid[g] && req_ready[g]):
  - Next cycle, resp_sum holds LOA(req_a[g], req_b[g]), resp_id=g, resp_valid=1.
  - rr pointer updates to g.
  - Latency is exactly 1 cycle.
- If accept=1 and no request is valid: resp_valid goes to 0 next cycle when resp_ready=1; otherwise it holds.
- Stall: while resp_valid=1 and resp_ready=0:
  - resp_sum and resp_id hold stable.
  - All req_ready=0.
  - rr pointer holds.
- LOA arithmetic (bit-exact):
  - s[15:0] = a[15:0] | b[15:0].
  - cM = a[15] & b[15].
  - s[31:16] = (a[31:16] + b[31:16] + cM) mod 2^16; carry-out dropped, no overflow flag.
- op_count:
  - Increments by 1 on each cycle with resp_valid && resp_ready.
  - Wraps from 0xFFFF_FFFF to 0.
- Simultaneous requests: exactly one grant per cycle; losers keep req_valid asserted and their operands stable until granted.
- Requester protocol: a requester must not drop req_valid or change operands before req_ready.
  - The block does not check this.
  - The block's behaviour when it is violated is undefined.

Decomposition:
- Shared package loa_share_pkg holds:
  - the constant DATA_W=32;
  - the constant LOA_M=16;
  - a function rr_next(ptr, valid) returning the grant index, reused by future arbiters.
- Sub-module rr_arbiter (NREQ parameter) contains:
  - inputs: valid vector, ptr, enable;
  - outputs: one-hot grant, encoded index.
- The existing LOA_16 module is instantiated once.
  - Its operands come from a mux driven by the encoded grant index.
  - Its output is captured into the result register.

Test Plan:
1. Carry into upper half: after reset, only req 0 valid, a=0x0000_8000, b=0x0000_8000 -> next cycle resp_valid=1, resp_sum=0x0001_8000, resp_id=0.
2. Lower bits ORed: req 2 valid with a=0x0000_000F, b=0x0000_0003 -> resp_sum=0x0000_000F, resp_id=2.
3. Upper-half wrap: a=0xFFFF_0000, b=0x0001_0000 -> resp_sum=0x0000_0000. Count op_count over two handshakes = 2.
4. Fairness: all 4 requesters held valid, resp_ready=1 -> resp_id sequence 0,1,2,3,0,1. Back-to-back resp_valid=1 with no bubbles.
5. Backpressure: resp_ready=0 for 5 cycles with requests pending -> resp_sum/resp_id stable, req_ready=0, op_count unchanged. Release -> next grant resumes round-robin from last pointer.
6. Reset mid-operation: assert rst with resp_valid=1 -> next cycle resp_valid=0, op_count=0. First grant after reset goes to requester 0 when all are valid.
